// File: rtl/ibex_fp_pkg.sv
// ibex_fp_pkg: shared types for the RV32F decode queue.
//   fpu_op_e   - FPU operation selector (FPU_NOP for memory ops and illegal encodings)
//   fp_mem_e   - memory access kind carried with the descriptor
//   fpu_dec_t  - decoded descriptor: op, resolved rm, mem kind, register indices,
//                integer-regfile flags, illegal flag
//   OPC_* / F7_* localparams for the RV32F major opcodes and OP-FP funct7 values.
package ibex_fp_pkg;

    typedef enum logic [4:0] {
        FPU_NOP,
        FPU_ADD,
        FPU_SUB,
        FPU_MUL,
        FPU_DIV,
        FPU_SQRT,
        FPU_MADD,
        FPU_MSUB,
        FPU_NMSUB,
        FPU_NMADD,
        FPU_SGNJ,
        FPU_SGNJ_N,
        FPU_SGNJ_X,
        FPU_MIN,
        FPU_MAX,
        FPU_CMP_LE,
        FPU_CMP_LT,
        FPU_CMP_EQ,
        FPU_FLOAT2INT,
        FPU_FLOAT2INT_U,
        FPU_INT2FLOAT,
        FPU_INT2FLOAT_U,
        FPU_MOVE_FLOAT2INT,
        FPU_MOVE_INT2FLOAT,
        FPU_CLASS
    } fpu_op_e;

    typedef enum logic [1:0] {
        FP_MEM_NONE  = 2'b00,
        FP_MEM_LOAD  = 2'b01,
        FP_MEM_STORE = 2'b10
    } fp_mem_e;

    typedef struct packed {
        fpu_op_e    op;
        logic [2:0] rm;
        fp_mem_e    mem;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rs3;
        logic [4:0] rd;
        logic       rd_int;
        logic       rs1_int;
        logic       illegal;
    } fpu_dec_t;

    // Major opcodes
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_MADD     = 7'b1000011;
    localparam logic [6:0] OPC_MSUB     = 7'b1000111;
    localparam logic [6:0] OPC_NMSUB    = 7'b1001011;
    localparam logic [6:0] OPC_NMADD    = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

    // OP-FP funct7
    localparam logic [6:0] F7_ADD     = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0000100;
    localparam logic [6:0] F7_MUL     = 7'b0001000;
    localparam logic [6:0] F7_DIV     = 7'b0001100;
    localparam logic [6:0] F7_SQRT    = 7'b0101100;
    localparam logic [6:0] F7_SGNJ    = 7'b0010000;
    localparam logic [6:0] F7_MINMAX  = 7'b0010100;
    localparam logic [6:0] F7_CMP     = 7'b1010000;
    localparam logic [6:0] F7_F2I     = 7'b1100000;
    localparam logic [6:0] F7_I2F     = 7'b1101000;
    localparam logic [6:0] F7_MV_X_CL = 7'b1110000;
    localparam logic [6:0] F7_MV_W_X  = 7'b1111000;

    localparam logic [2:0] RM_DYN = 3'b111;

    // Rounding modes 000..100 are defined; 101/110 are reserved.
    function automatic logic rm_legal(input logic [2:0] rm);
        return rm <= 3'b100;
    endfunction

endpackage

// File: rtl/fpu_decode_queue_decode.sv
// fpu_instr_decode: purely combinational RV32F decoder.
//   instr - raw 32-bit instruction
//   frm   - fcsr.frm, used when the instruction selects dynamic rounding
//   dec   - decoded descriptor; illegal encodings yield op=FPU_NOP, rm=0,
//           mem=none, flags=0, illegal=1 (register indices still pass through)
module fpu_instr_decode
    import ibex_fp_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [2:0]  frm,
    output fpu_dec_t    dec
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rs2;

    assign opcode = instr[6:0];
    assign funct7 = instr[31:25];
    assign funct3 = instr[14:12];
    assign rs2    = instr[24:20];

    fpu_op_e    op;
    fp_mem_e    mem;
    logic       legal;
    logic       rounds;
    logic       rd_int;
    logic       rs1_int;
    logic [2:0] rm;
    logic       rm_ok;

    // Opcode / funct decode
    always_comb begin
        op      = FPU_NOP;
        mem     = FP_MEM_NONE;
        legal   = 1'b1;
        rounds  = 1'b0;
        rd_int  = 1'b0;
        rs1_int = 1'b0;
        case (opcode)
            OPC_LOAD_FP: begin
                mem     = FP_MEM_LOAD;
                rs1_int = 1'b1;
                legal   = (funct3 == 3'b010);
            end
            OPC_STORE_FP: begin
                mem     = FP_MEM_STORE;
                rs1_int = 1'b1;
                legal   = (funct3 == 3'b010);
            end
            OPC_MADD: begin
                op = FPU_MADD;  rounds = 1'b1; legal = (instr[26:25] == 2'b00);
            end
            OPC_MSUB: begin
                op = FPU_MSUB;  rounds = 1'b1; legal = (instr[26:25] == 2'b00);
            end
            OPC_NMSUB: begin
                op = FPU_NMSUB; rounds = 1'b1; legal = (instr[26:25] == 2'b00);
            end
            OPC_NMADD: begin
                op = FPU_NMADD; rounds = 1'b1; legal = (instr[26:25] == 2'b00);
            end
            OPC_OP_FP: begin
                case (funct7)
                    F7_ADD: begin op = FPU_ADD; rounds = 1'b1; end
                    F7_SUB: begin op = FPU_SUB; rounds = 1'b1; end
                    F7_MUL: begin op = FPU_MUL; rounds = 1'b1; end
                    F7_DIV: begin op = FPU_DIV; rounds = 1'b1; end
                    F7_SQRT: begin
                        op = FPU_SQRT; rounds = 1'b1; legal = (rs2 == 5'd0);
                    end
                    F7_SGNJ: begin
                        case (funct3)
                            3'b000:  op = FPU_SGNJ;
                            3'b001:  op = FPU_SGNJ_N;
                            3'b010:  op = FPU_SGNJ_X;
                            default: legal = 1'b0;
                        endcase
                    end
                    F7_MINMAX: begin
                        case (funct3)
                            3'b000:  op = FPU_MIN;
                            3'b001:  op = FPU_MAX;
                            default: legal = 1'b0;
                        endcase
                    end
                    F7_CMP: begin
                        rd_int = 1'b1;
                        case (funct3)
                            3'b000:  op = FPU_CMP_LE;
                            3'b001:  op = FPU_CMP_LT;
                            3'b010:  op = FPU_CMP_EQ;
                            default: legal = 1'b0;
                        endcase
                    end
                    F7_F2I: begin
                        rd_int = 1'b1;
                        rounds = 1'b1;
                        case (rs2)
                            5'd0:    op = FPU_FLOAT2INT;
                            5'd1:    op = FPU_FLOAT2INT_U;
                            default: legal = 1'b0;
                        endcase
                    end
                    F7_I2F: begin
                        rs1_int = 1'b1;
                        rounds  = 1'b1;
                        case (rs2)
                            5'd0:    op = FPU_INT2FLOAT;
                            5'd1:    op = FPU_INT2FLOAT_U;
                            default: legal = 1'b0;
                        endcase
                    end
                    F7_MV_X_CL: begin
                        rd_int = 1'b1;
                        case (funct3)
                            3'b000:  op = FPU_MOVE_FLOAT2INT;
                            3'b001:  op = FPU_CLASS;
                            default: legal = 1'b0;
                        endcase
                        if (rs2 != 5'd0) legal = 1'b0;
                    end
                    F7_MV_W_X: begin
                        op      = FPU_MOVE_INT2FLOAT;
                        rs1_int = 1'b1;
                        legal   = (funct3 == 3'b000) && (rs2 == 5'd0);
                    end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    // Rounding-mode resolution; funct3 doubles as the rm field for rounding ops.
    always_comb begin
        rm    = 3'b000;
        rm_ok = 1'b1;
        if (rounds) begin
            if (funct3 == RM_DYN) begin
                rm    = frm;
                rm_ok = rm_legal(frm);
            end else begin
                rm    = funct3;
                rm_ok = rm_legal(funct3);
            end
        end
    end

    // Final descriptor; an illegal encoding clears everything but the indices.
    always_comb begin
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.rs3 = instr[31:27];
        dec.rd  = instr[11:7];
        if (legal && rm_ok) begin
            dec.op      = op;
            dec.rm      = rm;
            dec.mem     = mem;
            dec.rd_int  = rd_int;
            dec.rs1_int = rs1_int;
            dec.illegal = 1'b0;
        end else begin
            dec.op      = FPU_NOP;
            dec.rm      = 3'b000;
            dec.mem     = FP_MEM_NONE;
            dec.rd_int  = 1'b0;
            dec.rs1_int = 1'b0;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/fpu_decode_queue.sv
// fpu_decode_queue: RV32F decoder followed by a DEPTH-entry FIFO of
// {descriptor, tag}, sitting between instruction decode and FPU issue.
//   clk_i / rst_i           - clock, synchronous active-high reset
//   flush_i                 - drop every buffered entry (wins over same-cycle enqueue)
//   frm_i                   - fcsr.frm, captured into the descriptor at enqueue
//   in_valid/ready/instr/tag - enqueue handshake; in_ready_o = count < DEPTH
//   out_valid/ready + out_* - head descriptor and dequeue handshake
//   count_o                 - occupancy
// Head outputs are forced to zero while the queue is empty.
module fpu_decode_queue
    import ibex_fp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [2:0]                   frm_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [31:0]                  in_instr_i,
    input  logic [TAG_W-1:0]             in_tag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output fpu_op_e                      out_op_o,
    output logic [2:0]                   out_rm_o,
    output logic [1:0]                   out_mem_o,
    output logic [4:0]                   out_rs1_o,
    output logic [4:0]                   out_rs2_o,
    output logic [4:0]                   out_rs3_o,
    output logic [4:0]                   out_rd_o,
    output logic                         out_rd_int_o,
    output logic                         out_rs1_int_o,
    output logic                         out_illegal_o,
    output logic [TAG_W-1:0]             out_tag_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    fpu_dec_t dec_in;

    fpu_instr_decode u_dec (
        .instr (in_instr_i),
        .frm   (frm_i),
        .dec   (dec_in)
    );

    fpu_dec_t         dec_q [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             enq;
    logic             deq;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready depends only on occupancy: no path from out_ready_i.
    assign in_ready_o  = (count < CW'(DEPTH));
    assign out_valid_o = (count != '0);
    assign enq         = in_valid_i && in_ready_o;
    assign deq         = out_valid_o && out_ready_i;
    assign count_o     = count;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq) wptr <= ptr_inc(wptr);
            if (deq) rptr <= ptr_inc(rptr);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone defines which slots are live.
    always_ff @(posedge clk_i) begin
        if (enq && !flush_i && !rst_i) begin
            dec_q[wptr] <= dec_in;
            tag_q[wptr] <= in_tag_i;
        end
    end

    fpu_dec_t         head;
    logic [TAG_W-1:0] head_tag;

    assign head     = out_valid_o ? dec_q[rptr] : '0;
    assign head_tag = out_valid_o ? tag_q[rptr] : '0;

    assign out_op_o      = head.op;
    assign out_rm_o      = head.rm;
    assign out_mem_o     = head.mem;
    assign out_rs1_o     = head.rs1;
    assign out_rs2_o     = head.rs2;
    assign out_rs3_o     = head.rs3;
    assign out_rd_o      = head.rd;
    assign out_rd_int_o  = head.rd_int;
    assign out_rs1_int_o = head.rs1_int;
    assign out_illegal_o = head.illegal;
    assign out_tag_o     = head_tag;

endmodule

// File: tb/tb_fpu_decode_queue.sv
module tb_fpu_decode_queue;
    import ibex_fp_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             flush_i = 1'b0;
    logic [2:0]       frm_i = 3'b000;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [31:0]      in_instr_i = '0;
    logic [TAG_W-1:0] in_tag_i = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    fpu_op_e          out_op_o;
    logic [2:0]       out_rm_o;
    logic [1:0]       out_mem_o;
    logic [4:0]       out_rs1_o, out_rs2_o, out_rs3_o, out_rd_o;
    logic             out_rd_int_o, out_rs1_int_o, out_illegal_o;
    logic [TAG_W-1:0] out_tag_o;
    logic [2:0]       count_o;

    fpu_decode_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .frm_i(frm_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_instr_i(in_instr_i),
        .in_tag_i(in_tag_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_op_o(out_op_o), .out_rm_o(out_rm_o), .out_mem_o(out_mem_o),
        .out_rs1_o(out_rs1_o), .out_rs2_o(out_rs2_o), .out_rs3_o(out_rs3_o),
        .out_rd_o(out_rd_o), .out_rd_int_o(out_rd_int_o), .out_rs1_int_o(out_rs1_int_o),
        .out_illegal_o(out_illegal_o), .out_tag_o(out_tag_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [4:0] op;
        logic [2:0] rm;
        logic [1:0] mem;
        logic [4:0] rs1, rs2, rs3, rd;
        logic       rd_int, rs1_int, illegal;
        logic [3:0] tag;
    } exp_t;

    exp_t       sb[$];
    exp_t       act;
    exp_t       e_pop;
    int         checks = 0;
    int         failures = 0;
    logic [3:0] tag_n = 4'd0;

    function automatic exp_t mk(input logic [4:0] op, input logic [2:0] rm,
                                input logic [1:0] mem, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rs3,
                                input logic [4:0] rd, input logic rdi,
                                input logic rs1i, input logic ill);
        exp_t e;
        e = '{op: op, rm: rm, mem: mem, rs1: rs1, rs2: rs2, rs3: rs3, rd: rd,
              rd_int: rdi, rs1_int: rs1i, illegal: ill, tag: 4'd0};
        return e;
    endfunction

    function automatic logic [31:0] fadd_i(input logic [4:0] rd);
        return 32'h00208053 | (32'(rd) << 7);
    endfunction

    function automatic exp_t fadd_e(input logic [4:0] rd);
        return mk(FPU_ADD, 3'b000, 2'b00, 5'd1, 5'd2, 5'd0, rd, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Offer one instruction, waiting (bounded) for ready; scoreboard push on acceptance.
    task automatic offer(input logic [31:0] ins, input exp_t e);
        int n;
        n = 0;
        in_valid_i = 1'b1;
        in_instr_i = ins;
        in_tag_i   = tag_n;
        while (!in_ready_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!in_ready_o) begin
            checks++;
            failures++;
            $display("FAIL offer_timeout instr=%h got=not_ready exp=ready", ins);
        end else begin
            @(posedge clk_i); #1;
            e.tag = tag_n;
            sb.push_back(e);
        end
        in_valid_i = 1'b0;
        tag_n++;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while ((out_valid_o || count_o != 0) && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("drain_empty", {31'd0, out_valid_o}, 32'd0);
    endtask

    // Monitor: compare the head against the scoreboard on every dequeue.
    always @(negedge clk_i) begin
        if (!rst_i && out_valid_o && out_ready_i) begin
            act = '{op: out_op_o, rm: out_rm_o, mem: out_mem_o, rs1: out_rs1_o,
                    rs2: out_rs2_o, rs3: out_rs3_o, rd: out_rd_o, rd_int: out_rd_int_o,
                    rs1_int: out_rs1_int_o, illegal: out_illegal_o, tag: out_tag_o};
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_head got=%h exp=none", act);
            end else begin
                e_pop = sb.pop_front();
                if (act !== e_pop) begin
                    failures++;
                    $display("FAIL head_tag%0d got=%h exp=%h", e_pop.tag, act, e_pop);
                end
            end
        end
    end

    initial begin
        // Reset
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_ready", 32'(in_ready_o), 32'd1);
        chk("rst_data", {out_op_o, out_rm_o, out_rd_o, out_tag_o, out_illegal_o}, 32'd0);

        // Basic fadd, RNE; visible next cycle
        offer(32'h002081D3, mk(FPU_ADD, 3'b000, 2'b00, 5'd1, 5'd2, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0));
        chk("lat_valid", 32'(out_valid_o), 32'd1);
        chk("lat_count", 32'(count_o), 32'd1);
        chk("lat_op", 32'(out_op_o), 32'(FPU_ADD));

        // Dynamic rm captured at enqueue, then frm changes
        frm_i = 3'b010;
        offer(32'h0020F1D3, mk(FPU_ADD, 3'b010, 2'b00, 5'd1, 5'd2, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0));
        frm_i = 3'b011;
        @(posedge clk_i); #1;
        frm_i = 3'b101;
        offer(32'h0020F1D3, mk(FPU_NOP, 3'b000, 2'b00, 5'd1, 5'd2, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1));
        frm_i = 3'b000;
        chk("three_count", 32'(count_o), 32'd3);
        out_ready_i = 1'b1;
        wait_empty();

        // Streaming decode vectors; empty queue + ready gives no bypass
        offer(32'h18208243, mk(FPU_MADD, 3'b000, 2'b00, 5'd1, 5'd2, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0));
        chk("no_bypass_count", 32'(count_o), 32'd1);
        offer(32'h1820824B, mk(FPU_NMSUB, 3'b000, 2'b00, 5'd1, 5'd2, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0));
        offer(32'h0020D1D3, mk(FPU_NOP, 3'b000, 2'b00, 5'd1, 5'd2, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1));
        offer(32'h581081D3, mk(FPU_NOP, 3'b000, 2'b00, 5'd1, 5'd1, 5'd11, 5'd3, 1'b0, 1'b0, 1'b1));
        offer(32'h0000A087, mk(FPU_NOP, 3'b000, 2'b01, 5'd1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0));
        offer(32'h0020A027, mk(FPU_NOP, 3'b000, 2'b10, 5'd1, 5'd2, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0));
        offer(32'hC00092D3, mk(FPU_FLOAT2INT, 3'b001, 2'b00, 5'd1, 5'd0, 5'd24, 5'd5, 1'b1, 1'b0, 1'b0));
        offer(32'hA020A353, mk(FPU_CMP_EQ, 3'b000, 2'b00, 5'd1, 5'd2, 5'd20, 5'd6, 1'b1, 1'b0, 1'b0));
        wait_empty();

        // Fill to DEPTH, then dequeue concurrent with an offer
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) offer(fadd_i(5'(8 + i)), fadd_e(5'(8 + i)));
        chk("full_ready", 32'(in_ready_o), 32'd0);
        chk("full_count", 32'(count_o), 32'd4);
        in_valid_i  = 1'b1;
        in_instr_i  = fadd_i(5'd12);
        in_tag_i    = tag_n;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        chk("after_deq_ready", 32'(in_ready_o), 32'd1);
        chk("after_deq_count", 32'(count_o), 32'd3);
        @(posedge clk_i); #1;
        begin
            exp_t e;
            e = fadd_e(5'd12);
            e.tag = tag_n;
            sb.push_back(e);
        end
        in_valid_i = 1'b0;
        tag_n++;
        chk("refill_count", 32'(count_o), 32'd4);
        out_ready_i = 1'b1;
        for (int i = 5; i < 10; i++) offer(fadd_i(5'(8 + i)), fadd_e(5'(8 + i)));
        wait_empty();

        // Flush with concurrent enqueue
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) offer(fadd_i(5'(20 + i)), fadd_e(5'(20 + i)));
        chk("pre_flush_count", 32'(count_o), 32'd3);
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        in_instr_i = 32'h102081D3;
        in_tag_i   = tag_n;
        @(posedge clk_i); #1;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        tag_n++;
        sb.delete();
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_valid", 32'(out_valid_o), 32'd0);
        chk("flush_ready", 32'(in_ready_o), 32'd1);
        offer(32'h182081D3, mk(FPU_DIV, 3'b000, 2'b00, 5'd1, 5'd2, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0));
        out_ready_i = 1'b1;
        wait_empty();

        // Reset mid-stream drops entries
        out_ready_i = 1'b0;
        offer(fadd_i(5'd30), fadd_e(5'd30));
        offer(fadd_i(5'd31), fadd_e(5'd31));
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        sb.delete();
        chk("midrst_count", 32'(count_o), 32'd0);
        chk("midrst_valid", 32'(out_valid_o), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
